exu_muldiv_seq: RTL and testbench

//  Multi-cycle sequencer for RV64M multiply/divide, beside the single-cycle EXU.
//  EXU hands off M-extension ops over a valid/ready request channel.
//  The block runs an iterative shift-add multiplier or a restoring divider, then

---
 rtl/exu_muldiv_seq.sv | 209 ++++++++++++++++++++
 tb/tb_exu_muldiv_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/exu_muldiv_seq.sv
// exu_muldiv_seq
//   Multi-cycle RV64M multiply/divide sequencer sitting beside the
//   single-cycle EXU. Requests arrive on a valid/ready channel, are run
//   through an iterative shift-add multiplier or a restoring divider, and
//   the result is returned on a valid/ready response channel.
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-low reset
//   req_valid   request present
//   req_ready   request can be accepted (IDLE)
//   req_op      0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   req_word    *W variant (ignored for ops 1-3)
//   req_a       rs1 value
//   req_b       rs2 value
//   flush       abort the in-flight op, no response produced
//   resp_valid  result present
//   resp_ready  consumer takes the result
//   resp_data   result, held stable while resp_valid is high
//   busy        state != IDLE
//
// Configuration
//   MULDIV_EARLY_OUT_EN : multiply leaves CALC once the remaining multiplier
//                         bits are all zero (minimum one CALC cycle).
module exu_muldiv_seq #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;

    state_t state, state_nxt;

    logic [2:0]        op_q;
    logic              word_q;
    logic              neg_q;
    logic [6:0]        cnt;
    logic [2*XLEN-1:0] acc;     // product (mul) / partial remainder in [XLEN:0] (div)
    logic [2*XLEN-1:0] mcand;   // shifted multiplicand (mul) / divisor in [XLEN-1:0] (div)
    logic [XLEN-1:0]   mplier;  // remaining multiplier (mul) / dividend-quotient shift reg (div)

    // Request decode
    logic            is_div, word_eff, a_signed, b_signed, a_neg, b_neg;
    logic            div_zero, div_ovf, fast, accept;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_int, fast_res;

    always_comb begin
        is_div   = req_op[2];
        word_eff = req_word && (is_div || req_op == OP_MUL);
        a_signed = (req_op == OP_MULH) || (req_op == OP_MULHSU) || (is_div && !req_op[0]);
        b_signed = (req_op == OP_MULH) || (is_div && !req_op[0]);
        a_ext    = req_a;
        b_ext    = req_b;
        if (word_eff) begin
            a_ext = {{(XLEN-32){a_signed & req_a[31]}}, req_a[31:0]};
            b_ext = {{(XLEN-32){b_signed & req_b[31]}}, req_b[31:0]};
        end
        a_neg    = a_signed && a_ext[XLEN-1];
        b_neg    = b_signed && b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        min_int  = word_eff ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = is_div && (b_ext == '0);
        div_ovf  = is_div && !req_op[0] && (a_ext == min_int) && (b_ext == '1);
        fast     = div_zero || div_ovf;
        if (div_zero) begin
            if (req_op[1])
                fast_res = word_eff ? {{(XLEN-32){req_a[31]}}, req_a[31:0]} : req_a;
            else
                fast_res = '1;
        end else begin
            fast_res = req_op[1] ? '0 : a_ext;
        end
    end

    // One restoring-division step
    logic [XLEN:0] r_shift, r_diff;
    logic          r_ge;

    always_comb begin
        r_shift = {acc[XLEN-1:0], mplier[XLEN-1]};
        r_diff  = r_shift - {1'b0, mcand[XLEN-1:0]};
        r_ge    = !r_diff[XLEN];
    end

    logic early;
`ifdef MULDIV_EARLY_OUT_EN
    assign early = !op_q[2] && (mplier[XLEN-1:1] == '0);
`else
    assign early = 1'b0;
`endif

    logic calc_last;
    assign calc_last = (cnt == 7'd1) || early;

    // Sign fix-up and result selection
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   dres, res;

    always_comb begin
        prod = neg_q ? -acc : acc;
        dres = op_q[1] ? acc[XLEN-1:0] : mplier;
        if (neg_q)
            dres = -dres;
        if (op_q[2])
            res = dres;
        else if (op_q == OP_MUL)
            res = prod[XLEN-1:0];
        else
            res = prod[2*XLEN-1:XLEN];
        if (word_q)
            res = {{(XLEN-32){res[31]}}, res[31:0]};
    end

    // FSM
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req_ready  = (state == IDLE);
        busy       = (state != IDLE);
        resp_valid = (state == DONE);
        unique case (state)
            IDLE: begin
                accept = req_valid && !flush;
                if (accept)
                    state_nxt = fast ? DONE : CALC;
            end
            CALC: if (calc_last) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q      <= '0;
            word_q    <= 1'b0;
            neg_q     <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            resp_data <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q   <= req_op;
                    word_q <= word_eff;
                    neg_q  <= (is_div && req_op[1]) ? a_neg : (a_neg ^ b_neg);
                    cnt    <= word_eff ? 7'd32 : 7'd64;
                    acc    <= '0;
                    if (fast) begin
                        resp_data <= fast_res;
                    end else if (is_div) begin
                        mcand  <= {{XLEN{1'b0}}, b_mag};
                        // Word dividends are pre-aligned so the MSB-first loop starts at bit 31.
                        mplier <= word_eff ? (a_mag << 32) : a_mag;
                    end else begin
                        mcand  <= {{XLEN{1'b0}}, a_mag};
                        mplier <= b_mag;
                    end
                end
                CALC: begin
                    cnt <= cnt - 7'd1;
                    if (op_q[2]) begin
                        acc    <= {{(XLEN-1){1'b0}}, (r_ge ? r_diff : r_shift)};
                        mplier <= {mplier[XLEN-2:0], r_ge};
                    end else begin
                        if (mplier[0])
                            acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                end
                FIX: resp_data <= res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exu_muldiv_seq.sv
module tb_exu_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_word;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    exu_muldiv_seq #(.XLEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_word   (req_word),
        .req_a      (req_a),
        .req_b      (req_b),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
        int          lat_eo;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the acceptance edge.
    // Request inputs are scrambled afterwards so the latched copy must be used.
    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_word  = w;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = ~op;
        req_word  = ~w;
        req_a     = ~a;
        req_b     = ~b;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int exp_lat;
        int seen;

        vecs[0]  = '{3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 66, 5};
        vecs[1]  = '{3'd1, 1'b0, '1, '1, 64'd0, 66, 3};
        vecs[2]  = '{3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 66};
        vecs[3]  = '{3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 4};
        vecs[4]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 66};
        vecs[5]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 66};
        vecs[6]  = '{3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, 1};
        vecs[7]  = '{3'd5, 1'b0, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1};
        vecs[8]  = '{3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, 4};
        vecs[9]  = '{3'd5, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'd7, 64'd14, 34, 34};
        vecs[10] = '{3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, 34};
        vecs[11] = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 1};
        vecs[12] = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1, 1};
        vecs[13] = '{3'd7, 1'b1, 64'h0000_0000_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1, 1};
        vecs[14] = '{3'd5, 1'b0, '1, 64'd3, 64'h5555_5555_5555_5555, 66, 66};
        vecs[15] = '{3'd3, 1'b1, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 66, 5};
        vecs[16] = '{3'd6, 1'b1, 64'h0000_0000_8000_0000, '1, 64'd0, 1, 1};

        // Reset held with a request pending
        rst        = 1'b0;
        req_valid  = 1'b1;
        req_op     = 3'd0;
        req_word   = 1'b0;
        req_a      = 64'd3;
        req_b      = 64'd5;
        flush      = 1'b0;
        resp_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_req_ready", 64'(req_ready), 64'd1);
            check("rst_resp_valid", 64'(resp_valid), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_resp_data", resp_data, 64'd0);
        end
        req_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_busy", 64'(busy), 64'd0);

        // Vector table
        for (int i = 0; i < 17; i++) begin
`ifdef MULDIV_EARLY_OUT_EN
            exp_lat = vecs[i].lat_eo;
`else
            exp_lat = vecs[i].lat;
`endif
            issue(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b);
            wait_resp(lat);
            check($sformatf("vec%0d_data", i), resp_data, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_idle_after", i), 64'(req_ready), 64'd1);
        end

        // Backpressure: DIVU 100/7 held for 10 cycles
        resp_ready = 1'b0;
        issue(3'd5, 1'b0, 64'd100, 64'd7);
        wait_resp(lat);
        check("bp_latency", 64'(lat), 64'd66);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp_resp_valid", 64'(resp_valid), 64'd1);
            check("bp_resp_data", resp_data, 64'd14);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_req_ready", 64'(req_ready), 64'd1);
        check("bp_release_resp_valid", 64'(resp_valid), 64'd0);

        // Flush in the middle of a DIV
        issue(3'd4, 1'b0, 64'd100, 64'd7);
        repeat (19) @(posedge clk);
        #1;
        check("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy_after", 64'(busy), 64'd0);
        check("flush_req_ready", 64'(req_ready), 64'd1);
        seen = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        check("flush_no_resp", 64'(seen), 64'd0);

        issue(3'd7, 1'b0, 64'd10, 64'd3);
        wait_resp(lat);
        check("remu_after_flush_data", resp_data, 64'd1);
        check("remu_after_flush_latency", 64'(lat), 64'd66);
        @(posedge clk);
        #1;

        // Flush wins over a request in IDLE
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_word  = 1'b0;
        req_a     = 64'd1;
        req_b     = 64'd1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check("flush_idle_no_accept", 64'(busy), 64'd0);

        // Flush drops an unacknowledged response
        resp_ready = 1'b0;
        issue(3'd5, 1'b0, 64'd9, 64'd0);
        check("flush_done_valid_before", 64'(resp_valid), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_done_valid_after", 64'(resp_valid), 64'd0);
        check("flush_done_busy_after", 64'(busy), 64'd0);
        resp_ready = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
